// File: rtl/alu_pkg.sv
// Shared definitions for the sliced ALU: control-field layout, op codes,
// named control words and the FSM state type.
package alu_pkg;

  localparam int CON_AINV  = 3;
  localparam int CON_BINV  = 2;
  localparam int CON_OP_HI = 1;
  localparam int CON_OP_LO = 0;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } op_e;

  localparam logic [3:0] CON_AND  = 4'd0;
  localparam logic [3:0] CON_OR   = 4'd1;
  localparam logic [3:0] CON_ADD  = 4'd2;
  localparam logic [3:0] CON_SUB  = 4'd6;
  localparam logic [3:0] CON_SLT  = 4'd7;
  localparam logic [3:0] CON_SUB2 = 4'd10;
  localparam logic [3:0] CON_NOR  = 4'd12;
  localparam logic [3:0] CON_NAND = 4'd13;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU cell operating on already-inverted operands.
// SLT slices produce zero; the set bit is inserted by the top on the last slice.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  op_e              op,
  output logic [SLICE-1:0] res,
  output logic             cout,
  output logic             cmsb,
  output logic             smsb
);

  logic [SLICE:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + (SLICE+1)'(cin);
    cout = sum[SLICE];
    smsb = sum[SLICE-1];
    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    cmsb = sum[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = sum[SLICE-1:0];
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/sliced_alu.sv
// Multi-cycle integer ALU: WIDTH-bit operands processed SLICE bits per cycle,
// LSB first, with valid/ready handshakes on request and result sides.
module sliced_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       con,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carryout
);

  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  if (SLICE < 1 || WIDTH % SLICE != 0) begin : g_bad_cfg
    $error("sliced_alu: WIDTH must be a positive multiple of SLICE");
  end

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  op_e              op_q;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] res_s;
  logic             cout_s;
  logic             cmsb_s;
  logic             smsb_s;
  logic             ovf_fin;
  logic             slt_bit;
  logic             last;
  logic [WIDTH-1:0] res_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (cnt == LAST);

  // Operands are stored pre-inverted so every slice sees A' and B' directly.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q  <= con[CON_AINV] ? ~a : a;
      b_q  <= con[CON_BINV] ? ~b : b;
      op_q <= op_e'(con[CON_OP_HI:CON_OP_LO]);
    end
  end

  always_comb begin
    a_s = a_q[int'(cnt)*SLICE +: SLICE];
    b_s = b_q[int'(cnt)*SLICE +: SLICE];
  end

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_s),
    .b    (b_s),
    .cin  (carry_q),
    .op   (op_q),
    .res  (res_s),
    .cout (cout_s),
    .cmsb (cmsb_s),
    .smsb (smsb_s)
  );

  always_comb begin
    ovf_fin  = cmsb_s ^ cout_s;
    slt_bit  = smsb_s ^ ovf_fin;
    res_next = result;
    res_next[int'(cnt)*SLICE +: SLICE] = res_s;
    if (last && op_q == OP_SLT) begin
      res_next = WIDTH'(slt_bit);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      carry_q  <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      carryout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry_q <= con[CON_AINV] | con[CON_BINV];
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          result  <= res_next;
          carry_q <= cout_s;
          if (last) begin
            zero     <= (res_next == '0);
            overflow <= ovf_fin;
            carryout <= cout_s;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sliced_alu.sv
// Directed bench for sliced_alu with three instances: SLICE=8, SLICE=1, SLICE=32.
module tb_sliced_alu;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  con;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        zero      [3];
  logic        overflow  [3];
  logic        carryout  [3];
  logic [3:0]  con       [3];
  logic [31:0] a         [3];
  logic [31:0] b         [3];
  logic [31:0] result    [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sliced_alu #(.WIDTH(32), .SLICE(8)) u_s8 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .con(con[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .zero(zero[0]), .overflow(overflow[0]), .carryout(carryout[0])
  );
  sliced_alu #(.WIDTH(32), .SLICE(1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .con(con[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .zero(zero[1]), .overflow(overflow[1]), .carryout(carryout[1])
  );
  sliced_alu #(.WIDTH(32), .SLICE(32)) u_s32 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .con(con[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .result(result[2]), .zero(zero[2]), .overflow(overflow[2]), .carryout(carryout[2])
  );

  function automatic int ns_of(input int d);
    case (d)
      0:       return 4;
      1:       return 32;
      default: return 1;
    endcase
  endfunction

  task automatic start_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                          input logic [3:0] cv);
    @(negedge clk);
    a[d] = av; b[d] = bv; con[d] = cv; in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (out_valid[d] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake(input int d);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++; if (out_valid[d] !== 1'b0) $display("FAIL s%0d rst_out_valid: got %b want 0", d, out_valid[d]); else passed++;
      total++; if (result[d] !== 32'h0) $display("FAIL s%0d rst_result: got %h want 0", d, result[d]); else passed++;
      total++; if ({zero[d], overflow[d], carryout[d]} !== 3'b000)
        $display("FAIL s%0d rst_flags: got %b want 000", d, {zero[d], overflow[d], carryout[d]}); else passed++;
    end
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++; if (in_ready[d] !== 1'b1) $display("FAIL s%0d rst_in_ready: got %b want 1", d, in_ready[d]); else passed++;
    end
  endtask

  task automatic test_arith(input int d);
    vec_t tab [7];
    int   lat;
    tab[0] = '{32'h7FFFFFFF, 32'h00000001, CON_ADD,  32'h80000000, 1'b0, 1'b0, 1'b1};
    tab[1] = '{32'h00000005, 32'h00000005, CON_SUB,  32'h00000000, 1'b1, 1'b1, 1'b0};
    tab[2] = '{32'h00000003, 32'h0000000A, CON_SUB2, 32'h00000007, 1'b0, 1'b1, 1'b0};
    tab[3] = '{32'hFFFFFFFF, 32'h00000001, CON_SLT,  32'h00000001, 1'b0, 1'b1, 1'b0};
    tab[4] = '{32'h80000000, 32'h00000001, CON_SLT,  32'h00000001, 1'b0, 1'b1, 1'b1};
    tab[5] = '{32'h00000005, 32'h00000003, CON_SLT,  32'h00000000, 1'b1, 1'b1, 1'b0};
    tab[6] = '{32'h00000001, 32'h00000002, CON_ADD,  32'h00000003, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      start_op(d, tab[i].a, tab[i].b, tab[i].con);
      wait_done(d, lat);
      total++; if (lat != ns_of(d)) $display("FAIL s%0d arith%0d latency: got %0d want %0d", d, i, lat, ns_of(d)); else passed++;
      total++; if (result[d] !== tab[i].res) $display("FAIL s%0d arith%0d result: got %h want %h", d, i, result[d], tab[i].res); else passed++;
      total++; if ({zero[d], carryout[d], overflow[d]} !== {tab[i].z, tab[i].c, tab[i].o})
        $display("FAIL s%0d arith%0d flags(z,c,o): got %b want %b", d, i,
                 {zero[d], carryout[d], overflow[d]}, {tab[i].z, tab[i].c, tab[i].o}); else passed++;
      handshake(d);
      total++; if (in_ready[d] !== 1'b1) $display("FAIL s%0d arith%0d in_ready_after: got %b want 1", d, i, in_ready[d]); else passed++;
    end
  endtask

  task automatic test_logic(input int d);
    vec_t tab [4];
    int   lat;
    tab[0] = '{32'hF0F000FF, 32'h0FF00F0F, CON_AND,  32'h00F0000F, 1'b0, 1'b1, 1'b0};
    tab[1] = '{32'hF0F000FF, 32'h0FF00F0F, CON_OR,   32'hFFF00FFF, 1'b0, 1'b1, 1'b0};
    tab[2] = '{32'hF0F000FF, 32'h0FF00F0F, CON_NAND, 32'hFF0FFFF0, 1'b0, 1'b0, 1'b0};
    tab[3] = '{32'hF0F000FF, 32'h0FF00F0F, CON_NOR,  32'h000FF000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      start_op(d, tab[i].a, tab[i].b, tab[i].con);
      wait_done(d, lat);
      total++; if (result[d] !== tab[i].res) $display("FAIL s%0d logic%0d result: got %h want %h", d, i, result[d], tab[i].res); else passed++;
      total++; if ({zero[d], carryout[d], overflow[d]} !== {tab[i].z, tab[i].c, tab[i].o})
        $display("FAIL s%0d logic%0d flags(z,c,o): got %b want %b", d, i,
                 {zero[d], carryout[d], overflow[d]}, {tab[i].z, tab[i].c, tab[i].o}); else passed++;
      handshake(d);
    end
  endtask

  task automatic test_back_pressure(input int d);
    int lat;
    start_op(d, 32'd1000, 32'd234, CON_ADD);
    wait_done(d, lat);
    a[d] = 32'd100; b[d] = 32'd200; con[d] = CON_ADD; in_valid[d] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0)
        $display("FAIL s%0d bp_hold%0d valid/ready: got %b%b want 10", d, i, out_valid[d], in_ready[d]); else passed++;
      total++; if (result[d] !== 32'd1234) $display("FAIL s%0d bp_hold%0d result: got %0d want 1234", d, i, result[d]); else passed++;
    end
    handshake(d);
    total++; if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0)
      $display("FAIL s%0d bp_release ready/valid: got %b%b want 10", d, in_ready[d], out_valid[d]); else passed++;
    @(negedge clk);
    in_valid[d] = 1'b0;
    total++; if (in_ready[d] !== 1'b0) $display("FAIL s%0d bp_second_accept in_ready: got %b want 0", d, in_ready[d]); else passed++;
    wait_done(d, lat);
    total++; if (lat != ns_of(d)) $display("FAIL s%0d bp_second latency: got %0d want %0d", d, lat, ns_of(d)); else passed++;
    total++; if (result[d] !== 32'd300) $display("FAIL s%0d bp_second result: got %0d want 300", d, result[d]); else passed++;
    handshake(d);
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      a[d] = 32'h12345673; b[d] = 32'h0; con[d] = CON_ADD; in_valid[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) in_valid[d] = 1'b1;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++; if (out_valid[d] !== 1'b0) $display("FAIL s%0d midrst out_valid: got %b want 0", d, out_valid[d]); else passed++;
      total++; if (result[d] !== 32'h0) $display("FAIL s%0d midrst result: got %h want 0", d, result[d]); else passed++;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++; if (in_ready[d] !== 1'b1) $display("FAIL s%0d midrst no_accept in_ready: got %b want 1", d, in_ready[d]); else passed++;
    end
    for (int d = 0; d < 3; d++) begin
      start_op(d, 32'd1, 32'd2, CON_ADD);
      wait_done(d, lat);
      total++; if (lat != ns_of(d)) $display("FAIL s%0d post_rst latency: got %0d want %0d", d, lat, ns_of(d)); else passed++;
      total++; if (result[d] !== 32'd3) $display("FAIL s%0d post_rst result: got %0d want 3", d, result[d]); else passed++;
      handshake(d);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      a[d] = '0; b[d] = '0; con[d] = '0;
    end
    test_reset;
    for (int d = 0; d < 3; d++) begin
      test_arith(d);
      test_logic(d);
      test_back_pressure(d);
    end
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sliced_alu.md
# sliced_alu

Parametrised multi-cycle integer ALU and the WIDTH-bit successor to the one-bit ALU cell. It keeps the 4-bit control encoding: Ainvert, Binvert, 2-bit op. It processes operands SLICE bits per cycle, LSB first, and stores the carry between slices. It sits between the register-file read stage and writeback of the 32-bit datapath, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; NS = WIDTH/SLICE slice-cycles per operation (NS >= 1).
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; equals (state == IDLE).
- a, b  in  WIDTH  operands; sampled only on the accept edge.
- con  in  4  control: [3] Ainvert, [2] Binvert, [1:0] op (00 AND, 01 OR, 10 ADD, 11 SLT).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow of the adder path.
- carryout  out  1  carry out of the MSB of the adder path.

## Operation
- Effective operands: A' = con[3] ? ~a : a; B' = con[2] ? ~b : b.
- Carry into bit 0 = con[3] | con[2].
- Named codes:
  - 0 AND, 1 OR, 12 NOR, 13 NAND.
  - 2 ADD (a+b), 6 SUB (a-b), 10 SUB2 (b-a).
  - 7 SLT, signed a<b.
- Any other code is decoded by the same field rules; there is no error.
- The adder always runs. carryout and overflow are reported for every op, logic ops included.
- overflow = carry into MSB XOR carry out of MSB, taken on the final slice.
- SLT:
  - all result bits are 0 except bit 0.
  - bit 0 = sum[WIDTH-1] XOR overflow.
- zero is computed on the final result value.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch a, b, con, set carry = cin0, slice counter = 0, go to BUSY.
  - BUSY: each cycle, compute slice idx = counter on bits [idx*SLICE +: SLICE], write that result slice, store its carry-out, increment counter. After slice NS-1, finalise result, zero, overflow and carryout, then go to DONE.
  - DONE: out_valid=1; result and flags held stable. On out_ready, go to IDLE.
- in_ready is 0 in BUSY and DONE. in_valid there is ignored and nothing is queued.
- Input changes during BUSY or DONE have no effect.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, zero 0, overflow 0, carryout 0, internal carry 0, counter 0.
- Accept at clock edge k; out_valid rises after edge k+NS. Latency is NS cycles.
- Output handshake at edge m returns the block to IDLE; in_ready is 1 from the cycle after m.
- Maximum throughput is one operation per NS+2 cycles.
- Reset asserted mid-BUSY or mid-DONE:
  - all outputs and state clear immediately (asynchronously);
  - the operation is discarded;
  - nothing is accepted while reset is high.
- NS=1 (SLICE=WIDTH): BUSY lasts exactly one cycle.
- Counter width is max(1, $clog2(NS)); it stops at NS-1, with no wrap.
- Back-pressure: out_valid holds for as long as out_ready is low, with no cap.

## Structure
- Package alu_pkg holds:
  - con field positions;
  - op codes (OP_AND, OP_OR, OP_ADD, OP_SLT);
  - named control constants (CON_AND=0, CON_OR=1, CON_ADD=2, CON_SLT=7, CON_SUB=6, CON_SUB2=10, CON_NOR=12, CON_NAND=13);
  - the FSM state enum.
- Sub-module alu_slice (combinational, parameter SLICE):
  - inputs: A' slice, B' slice, carry-in, op;
  - outputs: result slice, carry-out, carry into its MSB, MSB sum bit.
- The top level holds the FSM, operand and result registers, counter and flags.

## Test plan
Default configuration is WIDTH=32, SLICE=8.
- ADD con=2, a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, carryout=0, zero=0; out_valid exactly 4 cycles after accept.
- Subtraction:
  - SUB con=6, a=5, b=5 -> result 0, zero=1, carryout=1, overflow=0.
  - SUB2 con=10, a=3, b=10 -> result 7.
- Logic ops with a=0xF0F000FF, b=0x0FF00F0F:
  - AND -> 0x00F0000F;
  - OR -> 0xFFF00FFF;
  - NAND -> 0xFF0FFFF0;
  - NOR -> 0x000FF000.
- SLT con=7:
  - a=0xFFFFFFFF, b=1 -> 1;
  - a=0x80000000, b=1 -> 1 with overflow=1;
  - a=5, b=3 -> 0.
- Back-pressure: hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands.
  - Required: result stable, in_ready=0, no second accept.
  - After the handshake: in_ready=1 the next cycle, and the queued-looking request is accepted only then.
- Reset pulse after 2 slices of an ADD -> out_valid=0 and result=0 immediately.
  - The following op (a=1, b=2, ADD) returns 3.
  - Repeat the whole suite with SLICE=1 (latency 32) and SLICE=32 (latency 1).
